// File: rtl/xbus_arbiter.sv
// Round-robin XBUS arbiter (POST_RST/ARB/ADDR/DATA); optional data-phase watchdog via XBUS_ARB_TIMEOUT_EN.
// Grant one clock after a request is sampled in ARB; no backpressure, DATA held until slave terminates.
module xbus_arbiter #(
    parameter int NUM_MASTERS    = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        sig_clock,
    input  logic        sig_reset_n,
    input  logic [15:0] sig_request,
    input  logic        sig_read,
    input  logic        sig_write,
    input  logic        sig_bip,
    input  logic        sig_wait,
    input  logic        sig_error,
    output logic        sig_start,
    output logic [15:0] sig_grant,
    output logic [3:0]  sig_grant_id,
    output logic        sig_timeout
);

    typedef enum logic [1:0] {POST_RST, ARB, ADDR, DATA} state_t;

    state_t      state_q, state_d;
    logic [15:0] grant_q, grant_d;
    logic [3:0]  gid_q, gid_d;
    logic [3:0]  rr_q, rr_d;
    logic [15:0] req_m;
    logic        found;
    logic [3:0]  win;
    logic [4:0]  idx;
    logic        data_done;
    logic        wd_fire;

    always_comb begin
        req_m = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < NUM_MASTERS) req_m[i] = sig_request[i];
        end
    end

    // Scan upward from rr_q, wrapping at NUM_MASTERS; first hit wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < 16; k++) begin
            idx = {1'b0, rr_q} + 5'(k);
            if (idx >= 5'(NUM_MASTERS)) idx = idx - 5'(NUM_MASTERS);
            if (!found && (k < NUM_MASTERS) && req_m[idx[3:0]]) begin
                found = 1'b1;
                win   = idx[3:0];
            end
        end
    end

    assign data_done = sig_error || (!sig_wait && !sig_bip);

`ifdef XBUS_ARB_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        tmo_q;

    assign wd_fire = (state_q == DATA) && (wd_q == 16'(TIMEOUT_CYCLES - 1)) && !data_done;

    always_comb begin
        wd_d = wd_q;
        if (state_q == ADDR)      wd_d = '0;
        else if (state_q == DATA) wd_d = wd_q + 16'd1;
    end

    always_ff @(posedge sig_clock or negedge sig_reset_n) begin
        if (!sig_reset_n) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            tmo_q <= wd_fire;
        end
    end

    assign sig_timeout = tmo_q;
`else
    assign wd_fire     = 1'b0;
    assign sig_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        rr_d    = rr_q;
        case (state_q)
            POST_RST: state_d = ARB;
            ARB: begin
                if (found) begin
                    state_d = ADDR;
                    grant_d = 16'd1 << win;
                    gid_d   = win;
                    rr_d    = (win == 4'(NUM_MASTERS - 1)) ? 4'd0 : win + 4'd1;
                end
            end
            ADDR: begin
                if (sig_read || sig_write) begin
                    state_d = DATA;
                end else begin
                    state_d = ARB;
                    grant_d = '0;
                    gid_d   = '0;
                end
            end
            DATA: begin
                if (data_done || wd_fire) begin
                    state_d = ARB;
                    grant_d = '0;
                    gid_d   = '0;
                end
            end
            default: state_d = POST_RST;
        endcase
    end

    always_ff @(posedge sig_clock or negedge sig_reset_n) begin
        if (!sig_reset_n) begin
            state_q <= POST_RST;
            grant_q <= '0;
            gid_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            rr_q    <= rr_d;
        end
    end

    assign sig_start    = (state_q == ARB);
    assign sig_grant    = grant_q;
    assign sig_grant_id = gid_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Bench for xbus_arbiter: a 16-master and a 5-master instance against a transaction-level model.
module tb_xbus_arbiter;

    localparam int TO = 8;
`ifdef XBUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req [2];
    logic        rd [2], wr [2], bip [2], wt [2], err [2];
    logic        st [2], tmo [2];
    logic [15:0] gr [2];
    logic [3:0]  gid [2];

    int total = 0;
    int bad   = 0;
    int ptr [2];
    int nm  [2];

    always #5 clk = ~clk;

    xbus_arbiter #(.NUM_MASTERS(16), .TIMEOUT_CYCLES(TO)) dut16 (
        .sig_clock(clk), .sig_reset_n(rst_n), .sig_request(req[0]),
        .sig_read(rd[0]), .sig_write(wr[0]), .sig_bip(bip[0]), .sig_wait(wt[0]),
        .sig_error(err[0]), .sig_start(st[0]), .sig_grant(gr[0]),
        .sig_grant_id(gid[0]), .sig_timeout(tmo[0]));

    xbus_arbiter #(.NUM_MASTERS(5), .TIMEOUT_CYCLES(TO)) dut5 (
        .sig_clock(clk), .sig_reset_n(rst_n), .sig_request(req[1]),
        .sig_read(rd[1]), .sig_write(wr[1]), .sig_bip(bip[1]), .sig_wait(wt[1]),
        .sig_error(err[1]), .sig_start(st[1]), .sig_grant(gr[1]),
        .sig_grant_id(gid[1]), .sig_timeout(tmo[1]));

    task automatic chk(input string tag, input int d, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear(input int d);
        req[d] = '0; rd[d] = 0; wr[d] = 0; bip[d] = 0; wt[d] = 0; err[d] = 0;
    endtask

    // Round-robin winner straight from the rule: first requester at or after ptr, modulo N.
    function automatic int model_win(input int d, input logic [15:0] rq);
        for (int k = 0; k < nm[d]; k++) begin
            int i;
            i = (ptr[d] + k) % nm[d];
            if (rq[i]) return i;
        end
        return -1;
    endfunction

    task automatic xfer(input int d, input logic [15:0] rq, input bit r, input bit w,
                        input int nbeats, input int err_at, input bit stuck, input bit rnd,
                        input int rst_at, output int win);
        int bl;
        bit ex, tf, wv, ev, bv;
        chk("arb_start", d, 16'(st[d]), 16'd1);
        chk("arb_grant", d, gr[d], 16'h0);
        chk("arb_tmo", d, 16'(tmo[d]), 16'd0);
        win = model_win(d, rq);
        req[d] = rq;
        cyc();
        if (win < 0) begin
            chk("idle_start", d, 16'(st[d]), 16'd1);
            chk("idle_grant", d, gr[d], 16'h0);
            req[d] = '0;
            return;
        end
        ptr[d] = (win + 1) % nm[d];
        chk("addr_grant", d, gr[d], 16'(1) << win);
        chk("addr_gid", d, 16'(gid[d]), 16'(win));
        chk("addr_start", d, 16'(st[d]), 16'd0);
        req[d] = 16'($urandom);
        rd[d] = r; wr[d] = w;
        cyc();
        rd[d] = 0; wr[d] = 0;
        if (!(r || w)) begin
            chk("nop_start", d, 16'(st[d]), 16'd1);
            chk("nop_grant", d, gr[d], 16'h0);
            chk("nop_gid", d, 16'(gid[d]), 16'd0);
            req[d] = '0;
            return;
        end
        bl = nbeats;
        for (int k = 0; k < 60; k++) begin
            chk("data_grant", d, gr[d], 16'(1) << win);
            chk("data_gid", d, 16'(gid[d]), 16'(win));
            chk("data_start", d, 16'(st[d]), 16'd0);
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_grant", d, gr[d], 16'h0);
                chk("rst_start", d, 16'(st[d]), 16'd0);
                chk("rst_gid", d, 16'(gid[d]), 16'd0);
                ptr[0] = 0; ptr[1] = 0;
                clear(0); clear(1);
                cyc();
                rst_n = 1'b1;
                chk("post_rst_start", d, 16'(st[d]), 16'd0);
                cyc();
                chk("rel_start", d, 16'(st[d]), 16'd1);
                return;
            end
            wv = stuck ? 1'b1 : (rnd ? ($urandom_range(0, 2) == 0) : 1'b0);
            if (k >= 30 && !stuck) wv = 1'b0;
            ev = (k == err_at) || (k == 50);
            bv = (bl > 1);
            wt[d] = wv; err[d] = ev; bip[d] = bv;
            ex = ev || (!wv && !bv);
            tf = TO_EN && (k == TO - 1) && !ex;
            cyc();
            if (!wv && bl > 1) bl--;
            if (ex || tf) begin
                clear(d);
                chk("end_grant", d, gr[d], 16'h0);
                chk("end_gid", d, 16'(gid[d]), 16'd0);
                chk("end_start", d, 16'(st[d]), 16'd1);
                chk("end_tmo", d, 16'(tmo[d]), 16'(tf));
                return;
            end
        end
    endtask

    initial begin
        int wn;
        nm[0] = 16; nm[1] = 5;
        ptr[0] = 0; ptr[1] = 0;
        clear(0); clear(1);

        // Reset and idle arbitration.
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst0_start", d, 16'(st[d]), 16'd0);
            chk("rst0_grant", d, gr[d], 16'h0);
            chk("rst0_gid", d, 16'(gid[d]), 16'd0);
            chk("rst0_tmo", d, 16'(tmo[d]), 16'd0);
        end
        cyc(); cyc();
        rst_n = 1'b1;
        chk("post_rst", 0, 16'(st[0]), 16'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("idle_arb_start", 0, 16'(st[0]), 16'd1);
            chk("idle_arb_grant", 0, gr[0], 16'h0);
        end

        // Fairness between masters 0 and 15.
        xfer(0, 16'h8001, 1, 0, 1, -1, 0, 0, -1, wn); chk("fair1", 0, 16'(wn), 16'd0);
        xfer(0, 16'h8001, 0, 1, 2, -1, 0, 0, -1, wn); chk("fair2", 0, 16'(wn), 16'd15);
        xfer(0, 16'h8001, 1, 0, 1, -1, 0, 0, -1, wn); chk("fair3", 0, 16'(wn), 16'd0);
        xfer(0, 16'h8001, 1, 1, 1, -1, 0, 0, -1, wn); chk("fair4", 0, 16'(wn), 16'd15);

        // Single two-beat write from master 2.
        xfer(0, 16'h0004, 0, 1, 2, -1, 0, 0, -1, wn); chk("single_win", 0, 16'(wn), 16'd2);
        // NOP address phase.
        xfer(0, 16'h0010, 0, 0, 1, -1, 0, 0, -1, wn); chk("nop_win", 0, 16'(wn), 16'd4);
        // Error with wait=1 on the second data cycle.
        xfer(0, 16'h0100, 1, 0, 3, 1, 1, 0, -1, wn); chk("err_win", 0, 16'(wn), 16'd8);
`ifdef XBUS_ARB_TIMEOUT_EN
        xfer(0, 16'h0200, 0, 1, 4, -1, 1, 0, -1, wn); chk("tmo_win", 0, 16'(wn), 16'd9);
`endif
        // Reset during the third data cycle, then rr pointer restarts at 0.
        xfer(0, 16'h0400, 1, 0, 6, -1, 0, 0, 2, wn);
        xfer(0, 16'h8001, 1, 0, 1, -1, 0, 0, -1, wn); chk("after_rst_win", 0, 16'(wn), 16'd0);

        // Masking on the narrow instance: only bits above 4 requested.
        xfer(1, 16'hffe0, 1, 0, 1, -1, 0, 0, -1, wn); chk("mask_win", 1, 16'(wn + 1), 16'd0);
        xfer(1, 16'h0011, 1, 0, 1, -1, 0, 0, -1, wn); chk("n5_win", 1, 16'(wn), 16'd0);
        xfer(1, 16'h0011, 1, 0, 1, -1, 0, 0, -1, wn); chk("n5_wrap", 1, 16'(wn), 16'd4);

        for (int t = 0; t < 120; t++) begin
            int d;
            logic [15:0] rq;
            d = int'($urandom_range(0, 1));
            rq = 16'($urandom) & 16'($urandom);
            xfer(d, rq, 1'($urandom), 1'($urandom), int'($urandom_range(1, 4)),
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1,
                 TO_EN && ($urandom_range(0, 9) == 0), 1'b1, -1, wn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
